// File: rtl/prefetch_scheduler.sv
// rtl/prefetch_scheduler.sv - per-scanline prefetch sequencer for background/foreground units
module prefetch_scheduler #(
   parameter int NUM_CLIENTS    = 2,
   parameter int VISIBLE_LINES  = 240,
   parameter int TOTAL_LINES    = 262,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   gpu_clk,
   input  logic                   rst,
   input  logic                   enable_i,
   input  logic                   line_start_i,
   input  logic                   frame_start_i,
   input  logic [NUM_CLIENTS-1:0] client_ready_i,
   input  logic                   clear_status_i,
   output logic [NUM_CLIENTS-1:0] prefetch_start_o,
   output logic [7:0]             prefetch_y_o,
   output logic                   busy_o,
   output logic [7:0]             overrun_count_o,
   output logic                   timeout_o
);

   localparam int LW = $clog2(TOTAL_LINES);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GUARD = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [LW-1:0]          line_q, line_d;
   logic [7:0]             y_q, y_d;
   logic [NUM_CLIENTS-1:0] mask_q, mask_d;
   logic [NUM_CLIENTS-1:0] start_q, start_d;
   logic [7:0]             ovr_q, ovr_d;
   logic                   tmo_flag_q, tmo_flag_d;
   logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;

   logic [LW-1:0]          target;
   logic                   req;
   logic [7:0]             inc;
   logic [9:0]             ovr_sum;

   // State, line counter and status registers; reset abandons any job in flight.
   always_ff @(posedge gpu_clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         line_q     <= '0;
         y_q        <= '0;
         mask_q     <= '0;
         start_q    <= '0;
         ovr_q      <= '0;
         tmo_flag_q <= 1'b0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         y_q        <= y_d;
         mask_q     <= mask_d;
         start_q    <= start_d;
         ovr_q      <= ovr_d;
         tmo_flag_q <= tmo_flag_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   // Next-state logic: line tracking, job sequencing and overrun accounting.
   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      y_d        = y_q;
      mask_d     = mask_q;
      start_d    = '0;
      tmo_cnt_d  = tmo_cnt_q;
      tmo_flag_d = tmo_flag_q;
      inc        = '0;

      // The target is derived from the already-advanced line number.
      if (frame_start_i) begin
         line_d = '0;
      end else if (line_start_i) begin
         line_d = (line_q == LW'(TOTAL_LINES - 1)) ? '0 : line_q + 1'b1;
      end
      target = (line_d == LW'(TOTAL_LINES - 1)) ? '0 : line_d + 1'b1;
      req    = line_start_i && enable_i && (target < LW'(VISIBLE_LINES));

      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_ISSUE;
               y_d     = 8'(target);
               mask_d  = client_ready_i;
            end
         end
         S_ISSUE: begin
            start_d = mask_q;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
               if (!mask_q[i]) inc = inc + 8'd1;
            end
            state_d = (mask_q == '0) ? S_IDLE : S_GUARD;
         end
         S_GUARD: begin
            // Clients may not have dropped ready yet; give them one cycle.
            state_d   = S_WAIT;
            tmo_cnt_d = '0;
         end
         S_WAIT: begin
            if ((client_ready_i & mask_q) == mask_q) begin
               state_d = S_IDLE;
            end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d    = S_IDLE;
               tmo_flag_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A request arriving mid-job is lost and recorded.
      if (req && state_q != S_IDLE) inc = inc + 8'd1;

      ovr_sum = {2'b00, ovr_q} + {2'b00, inc};
      ovr_d   = (ovr_sum > 10'd255) ? 8'd255 : ovr_sum[7:0];

      if (clear_status_i) begin
         ovr_d      = '0;
         tmo_flag_d = 1'b0;
      end
   end

   assign prefetch_start_o = start_q;
   assign prefetch_y_o     = y_q;
   assign busy_o           = (state_q != S_IDLE);
   assign overrun_count_o  = ovr_q;
   assign timeout_o        = tmo_flag_q;

endmodule

// File: tb/tb_prefetch_scheduler.sv
// tb/tb_prefetch_scheduler.sv - directed self-checking bench for prefetch_scheduler
module tb_prefetch_scheduler;

   logic       gpu_clk = 1'b0;
   logic       rst;
   logic       enable_i;
   logic       line_start_i;
   logic       frame_start_i;
   logic [1:0] client_ready_i;
   logic       clear_status_i;
   logic [1:0] prefetch_start_o;
   logic [7:0] prefetch_y_o;
   logic       busy_o;
   logic [7:0] overrun_count_o;
   logic       timeout_o;

   int n_checks = 0;
   int n_passed = 0;

   prefetch_scheduler #(
      .NUM_CLIENTS(2),
      .VISIBLE_LINES(240),
      .TOTAL_LINES(262),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .gpu_clk(gpu_clk),
      .rst(rst),
      .enable_i(enable_i),
      .line_start_i(line_start_i),
      .frame_start_i(frame_start_i),
      .client_ready_i(client_ready_i),
      .clear_status_i(clear_status_i),
      .prefetch_start_o(prefetch_start_o),
      .prefetch_y_o(prefetch_y_o),
      .busy_o(busy_o),
      .overrun_count_o(overrun_count_o),
      .timeout_o(timeout_o)
   );

   always #5 gpu_clk = ~gpu_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_passed++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge gpu_clk);
      #1;
   endtask

   task automatic pulse_line(input logic frame);
      line_start_i  = 1'b1;
      frame_start_i = frame;
      tick();
      line_start_i  = 1'b0;
      frame_start_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable_i = 1'b0; line_start_i = 1'b0; frame_start_i = 1'b0;
      client_ready_i = 2'b11; clear_status_i = 1'b0;
      tick(); tick();
      check("rst_start", prefetch_start_o, 0);
      check("rst_y", prefetch_y_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_ovr", overrun_count_o, 0);
      check("rst_tmo", timeout_o, 0);
      rst = 1'b0;
      enable_i = 1'b1;

      // Frame start with both units ready: issue line 1 to both.
      pulse_line(1'b1);
      check("f0_issue_busy", busy_o, 1);
      check("f0_issue_start", prefetch_start_o, 2'b00);
      tick();
      check("f0_start", prefetch_start_o, 2'b11);
      check("f0_y", prefetch_y_o, 1);
      client_ready_i = 2'b00;
      enable_i = 1'b0;
      tick();
      check("f0_wait_start", prefetch_start_o, 2'b00);
      check("f0_wait_busy", busy_o, 1);
      tick();
      check("f0_wait_busy2", busy_o, 1);
      client_ready_i = 2'b11;
      tick();
      check("f0_done_busy", busy_o, 0);
      check("f0_ovr", overrun_count_o, 0);
      enable_i = 1'b1;

      // Only client 0 ready: single pulse, one overrun.
      client_ready_i = 2'b01;
      pulse_line(1'b0);
      tick();
      check("part_start", prefetch_start_o, 2'b01);
      check("part_y", prefetch_y_o, 2);
      check("part_ovr", overrun_count_o, 1);
      tick(); tick();
      check("part_done", busy_o, 0);

      // Request arriving in WAIT is dropped.
      client_ready_i = 2'b11;
      pulse_line(1'b0);
      client_ready_i = 2'b00;
      tick();
      check("drop_first_start", prefetch_start_o, 2'b11);
      tick();
      pulse_line(1'b0);
      check("drop_start", prefetch_start_o, 2'b00);
      check("drop_ovr", overrun_count_o, 2);
      check("drop_y_held", prefetch_y_o, 3);
      client_ready_i = 2'b11;
      tick();
      check("drop_idle", busy_o, 0);

      // Last visible line and vblank boundaries.
      enable_i = 1'b0;
      pulse_line(1'b1);
      for (int i = 0; i < 237; i++) pulse_line(1'b0);
      enable_i = 1'b1;
      pulse_line(1'b0);
      tick();
      check("l238_start", prefetch_start_o, 2'b11);
      check("l238_y", prefetch_y_o, 239);
      tick(); tick();
      check("l238_idle", busy_o, 0);
      pulse_line(1'b0);
      check("l239_busy", busy_o, 0);
      tick();
      check("l239_start", prefetch_start_o, 2'b00);
      enable_i = 1'b0;
      for (int i = 0; i < 21; i++) pulse_line(1'b0);
      enable_i = 1'b1;
      pulse_line(1'b0);
      tick();
      check("l261_start", prefetch_start_o, 2'b11);
      check("l261_y", prefetch_y_o, 0);
      tick(); tick();

      // Timeout after 16 WAIT cycles, then normal issue.
      pulse_line(1'b0);
      tick();
      client_ready_i = 2'b00;
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("tmo_pre_busy", busy_o, 1);
      check("tmo_pre_flag", timeout_o, 0);
      tick();
      check("tmo_flag", timeout_o, 1);
      check("tmo_idle", busy_o, 0);
      client_ready_i = 2'b11;
      pulse_line(1'b0);
      tick();
      check("tmo_next_start", prefetch_start_o, 2'b11);
      check("tmo_next_y", prefetch_y_o, 2);
      tick(); tick();

      // Clear status.
      clear_status_i = 1'b1;
      tick();
      clear_status_i = 1'b0;
      check("clr_ovr", overrun_count_o, 0);
      check("clr_tmo", timeout_o, 0);

      // Same-cycle increments are summed: drop (+1) plus empty issue (+2).
      client_ready_i = 2'b00;
      pulse_line(1'b0);
      pulse_line(1'b0);
      check("sum_ovr", overrun_count_o, 3);
      check("sum_idle", busy_o, 0);

      // Clear wins over a same-cycle increment.
      pulse_line(1'b0);
      clear_status_i = 1'b1;
      tick();
      clear_status_i = 1'b0;
      check("clr_prio", overrun_count_o, 0);

      // Saturation: 150 empty-mask issues = 300 overruns.
      for (int i = 0; i < 150; i++) begin
         pulse_line(i == 0);
         tick();
         if (i == 0) check("sat_first", overrun_count_o, 2);
      end
      check("sat_ovr", overrun_count_o, 255);
      clear_status_i = 1'b1;
      tick();
      clear_status_i = 1'b0;
      check("sat_clr", overrun_count_o, 0);

      // Reset in GUARD abandons the job.
      client_ready_i = 2'b11;
      pulse_line(1'b0);
      tick();
      check("g_start", prefetch_start_o, 2'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("g_rst_start", prefetch_start_o, 2'b00);
      check("g_rst_busy", busy_o, 0);
      check("g_rst_y", prefetch_y_o, 0);
      tick();
      check("g_after_start", prefetch_start_o, 2'b00);
      check("g_after_busy", busy_o, 0);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/prefetch_scheduler.md
PREFETCH_SCHEDULER -- requirements
Module: prefetch_scheduler

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 2, number of scanline prefetch units sequenced (index 0 background, 1 foreground).
REQ-002 SHALL have parameter VISIBLE_LINES, default 240, number of displayed scanlines.
REQ-003 SHALL have parameter TOTAL_LINES, default 262, scanlines per frame including vblank.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum gpu_clk cycles allowed in WAIT.
REQ-005 gpu_clk  input  1  GPU clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 enable_i  input  1  when low, no new prefetches are issued.
REQ-008 line_start_i  input  1  single-cycle pulse at the start of every scanline.
REQ-009 frame_start_i  input  1  single-cycle pulse coincident with line_start_i of line 0.
REQ-010 client_ready_i  input  NUM_CLIENTS  per-client level, high when that prefetch unit is idle.
REQ-011 clear_status_i  input  1  single-cycle pulse clearing overrun_count_o and timeout_o.
REQ-012 prefetch_start_o  output  NUM_CLIENTS  per-client single-cycle start pulse.
REQ-013 prefetch_y_o  output  8  target scanline, held stable from ISSUE until return to IDLE.
REQ-014 busy_o  output  1  high in ISSUE, GUARD, WAIT.
REQ-015 overrun_count_o  output  8  saturating count of dropped or skipped prefetch requests.
REQ-016 timeout_o  output  1  sticky flag, WAIT exceeded TIMEOUT_CYCLES.

Function
REQ-017 SHALL keep a line counter 0..TOTAL_LINES-1: set to 0 on frame_start_i, else +1 on line_start_i, wrapping TOTAL_LINES-1 -> 0.
REQ-018 On each line_start_i, target = (current line + 1) mod TOTAL_LINES, where current line is the post-update value (0 when frame_start_i is high).
REQ-019 A request SHALL be raised only if enable_i=1 and target < VISIBLE_LINES; otherwise nothing happens.
REQ-020 SHALL implement states IDLE, ISSUE, GUARD, WAIT.
REQ-021 IDLE + request -> ISSUE next cycle; prefetch_y_o latches target; issue mask latches client_ready_i.
REQ-022 In ISSUE, SHALL pulse prefetch_start_o[i] for one cycle for every i in the issue mask.
REQ-023 Each client not in the mask SHALL add 1 to overrun_count_o.
REQ-024 An empty mask SHALL go directly to IDLE; otherwise ISSUE -> GUARD. GUARD lasts one cycle, ignores client_ready_i, and then goes to WAIT.
REQ-025 WAIT -> IDLE when client_ready_i is high for every masked client.
REQ-026 A timeout counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-027 On reaching TIMEOUT_CYCLES, SHALL set timeout_o, go to IDLE and abandon the job.
REQ-028 A request while not IDLE SHALL be dropped and add 1 to overrun_count_o; the line counter still advances.
REQ-029 overrun_count_o SHALL saturate at 255, and increments in one cycle SHALL be summed before saturation.
REQ-030 clear_status_i SHALL have priority over same-cycle increments and timeout set.
REQ-031 enable_i falling mid-job SHALL not abort it; the job completes normally.
REQ-032 prefetch_start_o SHALL be registered outputs, with 2-cycle latency from line_start_i.

Reset
REQ-033 On rst: state IDLE, line counter 0, prefetch_start_o 0, prefetch_y_o 0, busy_o 0, overrun_count_o 0, timeout_o 0, timeout counter 0.
REQ-034 rst mid-job SHALL abandon the job with no further start pulses and take priority over all inputs.

Verification
REQ-035 Both ready, frame_start_i+line_start_i -> 2 cycles later prefetch_start_o=2'b11, prefetch_y_o=1, busy_o until both ready return high.
REQ-036 Line counter at 238 then line_start_i -> prefetch_y_o=239; at 239 -> no request; at 261 -> prefetch_y_o=0.
REQ-037 client_ready_i=2'b01 at issue -> prefetch_start_o=2'b01 only, overrun_count_o +1.
REQ-038 line_start_i while in WAIT -> no pulse, overrun_count_o +1; 300 overruns -> 255; clear_status_i -> 0.
REQ-039 Client never re-asserts ready, TIMEOUT_CYCLES=16 -> timeout_o=1 after 16 WAIT cycles, state IDLE, next line issues normally.
REQ-040 rst asserted in GUARD -> next cycle all outputs at reset values, no pulse until a new request.
